// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for the 1Mx16 asynchronous SRAM: port 0 (read-only, priority), port 1 (read/write).
// Optional macro SRAM_ARB_STARVE_GUARD_EN forces a port-1 grant after STARVE_MAX port-0 grants while port 1 waits.
module sram_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_p0_req,
   input  logic [ADDR_W-1:0] i_p0_addr,
   output logic              o_p0_ack,
   output logic [DATA_W-1:0] o_p0_rdata,
   output logic              o_p0_rvalid,
   input  logic              i_p1_req,
   input  logic              i_p1_we,
   input  logic [ADDR_W-1:0] i_p1_addr,
   input  logic [DATA_W-1:0] i_p1_wdata,
   input  logic [1:0]        i_p1_be,
   output logic              o_p1_ack,
   output logic [DATA_W-1:0] o_p1_rdata,
   output logic              o_p1_rvalid,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n
);

   typedef enum logic [1:0] {IDLE, RD, WR, WREC} state_t;

   state_t            state;
   state_t            state_next;
   logic              grant0;
   logic              grant1;
   logic              force1;
   logic              rd_port;
   logic              dq_oe;
   logic [DATA_W-1:0] wdata_q;

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_cnt;

   assign force1 = i_p1_req && (starve_cnt >= CNT_W'(STARVE_MAX));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
      end else if (!i_p1_req || grant1) begin
         starve_cnt <= '0;
      end else if (grant0 && (starve_cnt != CNT_W'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign force1 = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // WR is the only state that cannot take a new request.
   always_comb begin
      state_next = IDLE;
      grant0     = 1'b0;
      grant1     = 1'b0;
      if (i_rst_n && (state != WR)) begin
         if (i_p0_req && !force1) begin
            grant0 = 1'b1;
         end else if (i_p1_req) begin
            grant1 = 1'b1;
         end
      end
      if (grant0) begin
         state_next = RD;
      end else if (grant1) begin
         state_next = i_p1_we ? WR : RD;
      end else if (state == WR) begin
         state_next = WREC;
      end
   end

   assign o_p0_ack = grant0;
   assign o_p1_ack = grant1;

   // Pins are registered from the next state so they line up with the state they describe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_sram_addr <= '0;
         o_sram_ce_n <= 1'b1;
         o_sram_oe_n <= 1'b1;
         o_sram_we_n <= 1'b1;
         o_sram_lb_n <= 1'b1;
         o_sram_ub_n <= 1'b1;
         dq_oe       <= 1'b0;
         wdata_q     <= '0;
         rd_port     <= 1'b0;
         o_p0_rdata  <= '0;
         o_p1_rdata  <= '0;
         o_p0_rvalid <= 1'b0;
         o_p1_rvalid <= 1'b0;
      end else begin
         o_p0_rvalid <= 1'b0;
         o_p1_rvalid <= 1'b0;
         if (state == RD) begin
            if (rd_port) begin
               o_p1_rdata  <= io_sram_dq;
               o_p1_rvalid <= 1'b1;
            end else begin
               o_p0_rdata  <= io_sram_dq;
               o_p0_rvalid <= 1'b1;
            end
         end
         if (grant0) begin
            o_sram_addr <= i_p0_addr;
            rd_port     <= 1'b0;
         end else if (grant1) begin
            o_sram_addr <= i_p1_addr;
            rd_port     <= 1'b1;
            wdata_q     <= i_p1_wdata;
         end
         o_sram_ce_n <= (state_next == IDLE);
         o_sram_oe_n <= (state_next != RD);
         o_sram_we_n <= (state_next != WR);
         dq_oe       <= (state_next == WR) || (state_next == WREC);
         case (state_next)
            RD: begin
               o_sram_lb_n <= 1'b0;
               o_sram_ub_n <= 1'b0;
            end
            WR: begin
               o_sram_lb_n <= ~i_p1_be[0];
               o_sram_ub_n <= ~i_p1_be[1];
            end
            WREC: begin
               o_sram_lb_n <= o_sram_lb_n;
               o_sram_ub_n <= o_sram_ub_n;
            end
            default: begin
               o_sram_lb_n <= 1'b1;
               o_sram_ub_n <= 1'b1;
            end
         endcase
      end
   end

   assign io_sram_dq = dq_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a transaction-level model and SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;
   localparam int STARVE_MAX = 8;
`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [19:0] p0_addr = '0, p1_addr = '0;
   logic [15:0] p1_wdata = '0;
   logic [1:0]  p1_be = '0;
   logic        p0_ack, p1_ack, p0_rvalid, p1_rvalid;
   logic [15:0] p0_rdata, p1_rdata;
   logic [19:0] addr;
   logic        ce_n, oe_n, we_n, lb_n, ub_n;
   wire  [15:0] dq;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_p0_req(p0_req), .i_p0_addr(p0_addr), .o_p0_ack(p0_ack),
      .o_p0_rdata(p0_rdata), .o_p0_rvalid(p0_rvalid),
      .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
      .i_p1_wdata(p1_wdata), .i_p1_be(p1_be), .o_p1_ack(p1_ack),
      .o_p1_rdata(p1_rdata), .o_p1_rvalid(p1_rvalid),
      .o_sram_addr(addr), .io_sram_dq(dq),
      .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
      .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
   );

   // Pin-level SRAM (low 4K words) and a zero-valued probe driver used to prove dq is released.
   logic [15:0] sram_mem [0:4095];
   logic        probe_en = 1'b1;
   logic        sram_drive;
   assign sram_drive = !ce_n && !oe_n && we_n;
   assign dq = sram_drive ? sram_mem[addr[11:0]] : (probe_en ? 16'h0000 : 16'hzzzz);

   // Transaction-level reference.
   logic [15:0] ref_mem [0:4095];
   int          total = 0, bad = 0;
   int          exp_state;              // 0 idle, 1 read cycle, 2 write strobe, 3 write recovery
   logic [19:0] exp_addr;
   logic [1:0]  exp_be;
   logic [15:0] exp_wdata;
   logic        e0, e1;
   logic        pv1, pp1, pv2, pp2;
   logic [15:0] pd1, pd2, held0, held1;
   int          cnt;
   logic        pend_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_state = 0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
      e0 = 1'b0; e1 = 1'b0;
      pv1 = 1'b0; pp1 = 1'b0; pv2 = 1'b0; pp2 = 1'b0;
      pd1 = '0; pd2 = '0; held0 = '0; held1 = '0;
      cnt = 0; pend_w = 1'b0;
   endtask

   // Negedge: let the SRAM absorb a write strobe, then compare every output against the model.
   task automatic check();
      logic [4:0] exp_pins;
      logic       avail, frc;
      @(negedge clk);
      if (!ce_n && !we_n) begin
         if (!lb_n) sram_mem[addr[11:0]][7:0]  = dq[7:0];
         if (!ub_n) sram_mem[addr[11:0]][15:8] = dq[15:8];
      end
      avail = rst_n && (exp_state != 2);
      frc   = GUARD && p1_req && (cnt >= STARVE_MAX);
      e0    = avail && p0_req && !frc;
      e1    = avail && p1_req && (!p0_req || frc);
      chk("ack0", p0_ack, e0);
      chk("ack1", p1_ack, e1);
      case (exp_state)
         1:       exp_pins = 5'b00100;
         2:       exp_pins = {3'b010, ~exp_be[0], ~exp_be[1]};
         3:       exp_pins = {3'b011, ~exp_be[0], ~exp_be[1]};
         default: exp_pins = 5'b11111;
      endcase
      chk("pins", {ce_n, oe_n, we_n, lb_n, ub_n}, exp_pins);
      chk("addr", addr, exp_addr);
      if (exp_state >= 2) chk("dq_drive", dq, exp_wdata);
      if (exp_state == 0) chk("dq_hiz", dq, 16'h0000);
      chk("rvalid0", p0_rvalid, pv2 && !pp2);
      chk("rvalid1", p1_rvalid, pv2 && pp2);
      chk("rdata0", p0_rdata, held0);
      chk("rdata1", p1_rdata, held1);
   endtask

   // Posedge: advance the model by one clock using the acceptances predicted in check().
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (exp_state == 2 && pend_w) begin
            if (exp_be[0]) ref_mem[exp_addr[11:0]][7:0]  = exp_wdata[7:0];
            if (exp_be[1]) ref_mem[exp_addr[11:0]][15:8] = exp_wdata[15:8];
            pend_w = 1'b0;
         end
         pv2 = pv1; pp2 = pp1; pd2 = pd1; pv1 = 1'b0;
         if (pv2) begin
            if (pp2) held1 = pd2;
            else     held0 = pd2;
         end
         if (!p1_req || e1) cnt = 0;
         else if (e0)       cnt++;
         if (e0) begin
            exp_state = 1; exp_addr = p0_addr;
            pv1 = 1'b1; pp1 = 1'b0; pd1 = ref_mem[p0_addr[11:0]];
            $display("txn port=0 rd addr=%05h exp=%04h", p0_addr, pd1);
         end else if (e1 && p1_we) begin
            exp_state = 2; exp_addr = p1_addr; exp_be = p1_be; exp_wdata = p1_wdata; pend_w = 1'b1;
            $display("txn port=1 wr addr=%05h data=%04h be=%b", p1_addr, p1_wdata, p1_be);
         end else if (e1) begin
            exp_state = 1; exp_addr = p1_addr;
            pv1 = 1'b1; pp1 = 1'b1; pd1 = ref_mem[p1_addr[11:0]];
            $display("txn port=1 rd addr=%05h exp=%04h", p1_addr, pd1);
         end else if (exp_state == 2) begin
            exp_state = 3;
         end else begin
            exp_state = 0;
         end
      end
      #1;
      probe_en = (exp_state == 0);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         check();
         tick();
      end
   endtask

   initial begin
      int   n0;
      logic got;
      for (int i = 0; i < 4096; i++) begin
         sram_mem[i] = 16'($urandom);
         ref_mem[i]  = sram_mem[i];
      end
      sram_mem[16'h0010] = 16'hBEEF;  ref_mem[16'h0010] = 16'hBEEF;
      sram_mem[16'h0100] = 16'h5566;  ref_mem[16'h0100] = 16'h5566;
      model_reset();

      // Reset: requests are ignored and all outputs sit at reset values.
      p0_req = 1'b1; p1_req = 1'b1;
      run(2);
      p0_req = 1'b0; p1_req = 1'b0;
      rst_n = 1'b1;
      run(2);

      // Single read.
      p0_req = 1'b1; p0_addr = 20'h00010;
      check(); chk("sr_ack", p0_ack, 1'b1); tick();
      p0_req = 1'b0;
      check(); chk("sr_oe", oe_n, 1'b0); chk("sr_addr", addr, 20'h00010); tick();
      check(); chk("sr_rvalid", p0_rvalid, 1'b1); chk("sr_rdata", p0_rdata, 16'hBEEF); tick();
      run(1);

      // Back-to-back reads at 0..3.
      for (int i = 0; i < 4; i++) begin
         p0_req = 1'b1; p0_addr = 20'(i);
         check(); chk("b2b_ack", p0_ack, 1'b1); tick();
      end
      p0_req = 1'b0;
      run(3);

      // Low-byte write and readback.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h00100; p1_wdata = 16'h12AB; p1_be = 2'b01;
      check(); tick();
      p1_req = 1'b0;
      check(); chk("bw_we", we_n, 1'b0); chk("bw_lb_ub", {lb_n, ub_n}, 2'b01); tick();
      check(); chk("bw_we_rec", we_n, 1'b1); chk("bw_dq", dq, 16'h12AB); tick();
      p1_req = 1'b1; p1_we = 1'b0;
      check(); tick();
      p1_req = 1'b0;
      run(1);
      check(); chk("bw_readback", p1_rdata, 16'h55AB); tick();

      // Contention.
      p0_req = 1'b1; p0_addr = 20'h00030; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 20'h00020;
      check(); chk("ct_p0_first", {p0_ack, p1_ack}, 2'b10); tick();
      p0_req = 1'b0;
      check(); chk("ct_p1_next", p1_ack, 1'b1); tick();
      p1_req = 1'b0;
      run(3);

      // Starvation: port 0 reads continuously while port 1 waits.
      n0 = 0; got = 1'b0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 20'h00040;
      for (int k = 0; k < 20; k++) begin
         p0_req = 1'b1; p0_addr = 20'(k + 64);
         check();
         if (p1_ack && !got) begin
            got = 1'b1;
            chk("starve_bound", n0 <= STARVE_MAX, 1'b1);
         end
         if (p0_ack && !got) n0++;
         tick();
         if (got) p1_req = 1'b0;
      end
`ifdef SRAM_ARB_STARVE_GUARD_EN
      chk("starve_acked", got, 1'b1);
`else
      chk("starve_never", got, 1'b0);
`endif
      p0_req = 1'b0; p1_req = 1'b0;
      run(3);

      // Random traffic; a request is held until accepted.
      for (int c = 0; c < 400; c++) begin
         if (!p0_req || e0) begin
            p0_req  = ($urandom_range(0, 99) < 50);
            p0_addr = 20'($urandom_range(0, 4095));
         end
         if (!p1_req || e1) begin
            p1_req   = ($urandom_range(0, 99) < 50);
            p1_we    = 1'($urandom_range(0, 1));
            p1_addr  = 20'($urandom_range(0, 4095));
            p1_wdata = 16'($urandom);
            p1_be    = 2'($urandom_range(0, 3));
         end
         check();
         tick();
      end
      p0_req = 1'b0; p1_req = 1'b0;
      run(3);

      // Reset asserted during the write strobe.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h00200; p1_wdata = 16'hA5A5; p1_be = 2'b11;
      check(); chk("rw_ack", p1_ack, 1'b1); tick();
      p1_req = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      probe_en = 1'b1;
      #1;
      chk("rw_async_pins", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
      chk("rw_async_dq", dq, 16'h0000);
      check(); tick();
      rst_n = 1'b1;
      run(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
